dcache_nway: RTL
================

# dcache_nway

Parametrised N-way set-associative, write-back, write-allocate data cache between the datapath's data port and the memory controller's data channel. It replaces the pass-through data path in the cache wrapper: hits complete in the request cycle, misses run a write-back/fill sequence against memory, and a halt triggers a full flush that raises `flushed` when memory is coherent.

## Interface
- `SETS`, 8, number of sets (power of two, ≥2)
- `WAYS`, 2, associativity (1, 2 or 4)
- `BLOCK_WORDS`, 2, 32-bit words per block (power of two, ≥1)
- `CLK`  in  1  clock; all state updates on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `dmemREN`, `dmemWEN`  in  1  datapath read / write request, held until `dhit`
- `dmemaddr`  in  32  byte address; bits [1:0] ignored
- `dmemstore`  in  32  write data
- `halt`  in  1  datapath halted; starts flush
- `dhit`  out  1  request complete this cycle
- `dmemload`  out  32  read data, valid with `dhit`
- `flushed`  out  1  flush complete, sticky
- `dREN`, `dWEN`  out  1  memory read / write request
- `daddr`  out  32  memory word address
- `dstore`  out  32  memory write data
- `dwait`  in  1  memory busy; a word transfer completes in any cycle with request high and `dwait`=0
- `dload`  in  32  memory read data, valid when `dwait`=0

## Operation
- Address split: [1:0] byte, next log2(BLOCK_WORDS) bits word offset, next log2(SETS) bits index, remainder tag.
- Per line: valid, dirty, tag, BLOCK_WORDS data words; per set, one log2(WAYS)-bit age per way (LRU).
- Simultaneous `dmemREN` and `dmemWEN` is treated as a write.
- States: IDLE, WB, FILL, FLUSH, DONE.
- IDLE: lookup is combinational. Hit → `dhit`=1, `dmemload`=hit word (0 otherwise); write hit stores `dmemstore` at the edge and sets dirty; accessed way's age→0, ways with smaller age +1.
- Miss, victim = lowest-index invalid way, else way with age WAYS-1. Victim dirty → WB, else FILL.
- WB: `dWEN`=1, `daddr`={victim tag, index, word, 2'b00}, word counter 0..BLOCK_WORDS-1 advancing on each completed transfer; after last word clear dirty → FILL.
- FILL: `dREN`=1, `daddr`={request tag, index, word, 2'b00}; write `dload` into victim on each completed transfer; after last word set valid, tag, dirty=0 → IDLE. The still-held request hits on the next cycle.
- `halt` sampled in IDLE only (an in-flight miss finishes first; a request and `halt` in the same IDLE cycle: halt wins, `dhit`=0) → FLUSH.
- FLUSH: scan set 0..SETS-1, way 0..WAYS-1; dirty lines written back word-by-word as in WB; every line invalidated; after last line → DONE.
- DONE: `flushed`=1, `dhit`=0, no memory requests; exit only by `RST`.

## Timing
- Reset (any state, including mid-WB/FILL/FLUSH): next cycle state IDLE, all valid/dirty/age cleared, counters 0, `flushed`=0; `dREN`/`dWEN`/`dhit`=0, `daddr`=`dstore`=`dmemload`=0. Dirty data in flight is discarded.
- Hit latency 0 cycles (`dhit` same cycle as request).
- Clean miss: BLOCK_WORDS completed reads, then hit the following cycle; dirty miss adds BLOCK_WORDS completed writes before the reads.
- `dREN` and `dWEN` never high together; `daddr`/`dstore` stable while `dwait`=1.
- `dhit` is 0 in WB, FILL, FLUSH, DONE.
- Age counters saturate naturally (max WAYS-1); with WAYS=1 age logic is absent and victim is way 0.

## Test plan
(SETS=8, WAYS=2, BLOCK_WORDS=2, memory `dwait` low 2 cycles after each request.)
- Read miss 0x40, mem[0x40]=0xAAAA0001, mem[0x44]=0xAAAA0002 → `dREN` at 0x40 then 0x44, no `dWEN`; next cycle `dhit`=1, `dmemload`=0xAAAA0001; read 0x44 → same-cycle hit 0xAAAA0002.
- Write 0x40←0x12345678 after fill → same-cycle `dhit`, no memory traffic; read 0x40 → 0x12345678.
- Dirty 0x40, read 0x80, then 0xC0 (all index 0) → 0x40 line evicted: `dWEN` 0x40=0x12345678, 0x44, then `dREN` 0xC0, 0xC4; 0x80 still hits.
- `halt` with two dirty lines (sets 0 and 3) → exactly four writes in set order, then `flushed`=1 held; later requests get `dhit`=0.
- `RST` during second FILL word → next cycle all outputs 0, state IDLE; read of the aborted address misses again.
- Simultaneous `dmemREN`/`dmemWEN` hit at 0x40 → handled as write, line dirty.

Source files
------------

// File: rtl/dcache_nway_if.sv
// Datapath-to-cache and cache-to-memory signal bundle for dcache_nway.
// Latency: none; wires only.
// Backpressure: the datapath holds its request until dhit; the memory side stalls with dwait.
interface dcache_nway_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with LRU ages and halt flush.
// Latency: hits complete in the request cycle; misses take one block write-back (if dirty) plus one block fill.
// Backpressure: dhit stays low until the request is served; every memory word waits for dwait=0.
module dcache_nway #(
    parameter int SETS        = 8,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 2
) (
    input  logic          CLK,
    input  logic          RST,
    dcache_nway_if.slave  bus
);
    localparam int OB = $clog2(BLOCK_WORDS);
    localparam int OW = (OB > 0) ? OB : 1;
    localparam int IB = $clog2(SETS);
    localparam int TW = 30 - OB - IB;
    localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FLUSH, S_DONE} state_t;
    state_t r_state, w_next;

    logic          r_valid [SETS][WAYS];
    logic          r_dirty [SETS][WAYS];
    logic [TW-1:0] r_tag   [SETS][WAYS];
    logic [AW-1:0] r_age   [SETS][WAYS];
    logic [31:0]   r_data  [SETS][WAYS][BLOCK_WORDS];

    logic [IB-1:0] r_idx, r_fset;
    logic [TW-1:0] r_rtag;
    logic [AW-1:0] r_vway, r_fway;
    logic [OW-1:0] r_word;

    logic [TW-1:0] w_tag;
    logic [IB-1:0] w_idx;
    logic [OW-1:0] w_off;
    logic          w_req, w_hit, w_vdirty, w_fl_dirty, w_mem_req, w_xfer;
    logic          w_last_word, w_last_line, w_unused;
    logic [AW-1:0] w_hit_way, w_vic, w_vic_age;

    function automatic logic [31:0] f_addr(input logic [TW-1:0] t, input logic [IB-1:0] i,
                                           input logic [OW-1:0] w);
        return (32'(t) << (2 + OB + IB)) | (32'(i) << (2 + OB)) | (32'(w) << 2);
    endfunction

    assign w_tag    = bus.dmemaddr[31 -: TW];
    assign w_idx    = bus.dmemaddr[2 + OB +: IB];
    assign w_unused = ^bus.dmemaddr[1:0];
    generate
        if (OB > 0) begin : g_off
            assign w_off = bus.dmemaddr[2 +: OW];
        end else begin : g_no_off
            assign w_off = '0;
        end
    endgenerate

    assign w_req       = bus.dmemREN || bus.dmemWEN;
    assign w_fl_dirty  = r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway];
    assign w_vdirty    = r_valid[w_idx][w_vic] && r_dirty[w_idx][w_vic];
    assign w_last_word = (r_word == OW'(BLOCK_WORDS - 1));
    assign w_last_line = (r_fset == IB'(SETS - 1)) && (r_fway == AW'(WAYS - 1));
    assign w_mem_req   = (r_state == S_WB) || (r_state == S_FILL) || (r_state == S_FLUSH && w_fl_dirty);
    assign w_xfer      = w_mem_req && !bus.dwait;

    // Tag compare across the indexed set; lowest matching way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = AW'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the oldest way. Cold ways never age, so ties are
    // possible and resolve to the lowest index.
    always_comb begin
        w_vic     = '0;
        w_vic_age = r_age[w_idx][0];
        for (int w = 1; w < WAYS; w++) begin
            if (r_age[w_idx][w] > w_vic_age) begin
                w_vic     = AW'(w);
                w_vic_age = r_age[w_idx][w];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_vic = AW'(w);
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; halt is only honoured between requests.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.halt)            w_next = S_FLUSH;
                     else if (w_req && !w_hit) w_next = w_vdirty ? S_WB : S_FILL;
            S_WB:    if (w_xfer && w_last_word) w_next = S_FILL;
            S_FILL:  if (w_xfer && w_last_word) w_next = S_IDLE;
            S_FLUSH: if ((!w_fl_dirty || (w_xfer && w_last_word)) && w_last_line) w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs: hit data to the datapath, word requests to memory.
    always_comb begin
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
        bus.flushed  = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        case (r_state)
            S_IDLE: if (w_req && w_hit && !bus.halt) begin
                bus.dhit     = 1'b1;
                bus.dmemload = r_data[w_idx][w_hit_way][w_off];
            end
            S_WB: begin
                bus.dWEN   = 1'b1;
                bus.daddr  = f_addr(r_tag[r_idx][r_vway], r_idx, r_word);
                bus.dstore = r_data[r_idx][r_vway][r_word];
            end
            S_FILL: begin
                bus.dREN  = 1'b1;
                bus.daddr = f_addr(r_rtag, r_idx, r_word);
            end
            S_FLUSH: if (w_fl_dirty) begin
                bus.dWEN   = 1'b1;
                bus.daddr  = f_addr(r_tag[r_fset][r_fway], r_fset, r_word);
                bus.dstore = r_data[r_fset][r_fway][r_word];
            end
            S_DONE: bus.flushed = 1'b1;
            default: ;
        endcase
    end

    // Line state, data array, LRU ages and transfer counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_age[s][w]   <= '0;
                end
            end
            r_idx  <= '0;
            r_rtag <= '0;
            r_vway <= '0;
            r_word <= '0;
            r_fset <= '0;
            r_fway <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.halt) begin
                        r_fset <= '0;
                        r_fway <= '0;
                        r_word <= '0;
                    end else if (w_req && w_hit) begin
                        if (bus.dmemWEN) begin
                            r_data[w_idx][w_hit_way][w_off] <= bus.dmemstore;
                            r_dirty[w_idx][w_hit_way]       <= 1'b1;
                        end
                        if (WAYS > 1) begin
                            for (int w = 0; w < WAYS; w++) begin
                                if (AW'(w) == w_hit_way)
                                    r_age[w_idx][w] <= '0;
                                else if (r_age[w_idx][w] < r_age[w_idx][w_hit_way])
                                    r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                            end
                        end
                    end else if (w_req) begin
                        r_idx  <= w_idx;
                        r_rtag <= w_tag;
                        r_vway <= w_vic;
                        r_word <= '0;
                    end
                end
                S_WB: if (w_xfer) begin
                    r_word <= w_last_word ? '0 : r_word + 1'b1;
                    if (w_last_word) r_dirty[r_idx][r_vway] <= 1'b0;
                end
                S_FILL: if (w_xfer) begin
                    r_data[r_idx][r_vway][r_word] <= bus.dload;
                    r_word <= w_last_word ? '0 : r_word + 1'b1;
                    if (w_last_word) begin
                        r_valid[r_idx][r_vway] <= 1'b1;
                        r_dirty[r_idx][r_vway] <= 1'b0;
                        r_tag[r_idx][r_vway]   <= r_rtag;
                    end
                end
                S_FLUSH: if (!w_fl_dirty || (w_xfer && w_last_word)) begin
                    r_valid[r_fset][r_fway] <= 1'b0;
                    r_dirty[r_fset][r_fway] <= 1'b0;
                    r_word                  <= '0;
                    if (r_fway == AW'(WAYS - 1)) begin
                        r_fway <= '0;
                        r_fset <= r_fset + 1'b1;
                    end else begin
                        r_fway <= r_fway + 1'b1;
                    end
                end else if (w_xfer) begin
                    r_word <= r_word + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
